thumb_fetch_sequencer: RTL and testbench

Sequences fetched 32-bit words into the IF/ID pipeline register that feeds the Thumb decoder wrapper. In ARM state each word issues once. In Thumb state each word issues as two consecutive halfword slots, low then high, with address bit 1 marking the slot. It backpressures fetch, honours decode stalls, and drops buffered words on a PC change from EX or MEM.

---
 rtl/thumb_fetch_sequencer.sv | 133 +++++++++++++
 tb/tb_thumb_fetch_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/thumb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : thumb_fetch_sequencer
// Brief   : Issues fetched words into IF/ID, one slot per ARM word or two
//           halfword slots per Thumb word. Optional skid: THUMB_FETCH_SKID_EN.
// Revision: 1.0 - initial release
// ============================================================================
module thumb_fetch_sequencer #(
  parameter int INST_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_FetchValid,
  input  logic [INST_W-1:0] in_FetchWord,
  input  logic [ADDR_W-1:0] in_FetchAddress,
  input  logic              in_ThumbState,
  input  logic              in_DecodeStall,
  input  logic              in_ChangePC,
  input  logic              in_MEMChangePC,
  output logic              out_FetchReady,
  output logic              out_ValidInstruction_IFID,
  output logic [INST_W-1:0] out_PipelineRegister_IFID,
  output logic [ADDR_W-1:0] out_AddressGoWithInstruction,
  output logic              out_ThumbState_IFID
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ARM   = 2'd1,
    LOW   = 2'd2,
    HIGH  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_valid;
  logic [INST_W-1:0]   r_word;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_thumb;

  logic                w_flush;
  logic                w_lastSlot;
  logic                w_advance;
  logic                w_accept;
  logic                w_load;
  logic [INST_W-1:0]   w_srcWord;
  logic [ADDR_W-1:1]   w_srcAddr;
  logic                w_srcThumb;
  logic                w_unusedAddrBit0;

  assign w_unusedAddrBit0 = in_FetchAddress[0];

  assign w_flush    = in_ChangePC | in_MEMChangePC;
  assign w_lastSlot = (r_state == ARM) || (r_state == HIGH);
  assign w_advance  = (r_state == EMPTY) || (w_lastSlot && !in_DecodeStall);
  assign w_accept   = in_FetchValid && out_FetchReady;

`ifdef THUMB_FETCH_SKID_EN
  logic                r_skidValid;
  logic [INST_W-1:0]   r_skidWord;
  logic [ADDR_W-1:1]   r_skidAddr;
  logic                r_skidThumb;

  // A full skid still accepts when IF/ID drains it in the same cycle.
  assign out_FetchReady = !w_flush && (!r_skidValid || w_advance);
  assign w_load         = w_advance && (r_skidValid || w_accept);
  assign w_srcWord      = r_skidValid ? r_skidWord  : in_FetchWord;
  assign w_srcAddr      = r_skidValid ? r_skidAddr  : in_FetchAddress[ADDR_W-1:1];
  assign w_srcThumb     = r_skidValid ? r_skidThumb : in_ThumbState;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_skidValid <= 1'b0;
      r_skidWord  <= '0;
      r_skidAddr  <= '0;
      r_skidThumb <= 1'b0;
    end else if (w_flush) begin
      r_skidValid <= 1'b0;
    end else if (w_accept && !(w_advance && !r_skidValid)) begin
      r_skidValid <= 1'b1;
      r_skidWord  <= in_FetchWord;
      r_skidAddr  <= in_FetchAddress[ADDR_W-1:1];
      r_skidThumb <= in_ThumbState;
    end else if (w_advance && r_skidValid) begin
      r_skidValid <= 1'b0;
    end
  end
`else
  assign out_FetchReady = !w_flush && w_advance;
  assign w_load         = w_accept;
  assign w_srcWord      = in_FetchWord;
  assign w_srcAddr      = in_FetchAddress[ADDR_W-1:1];
  assign w_srcThumb     = in_ThumbState;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
      r_word  <= '0;
      r_addr  <= '0;
      r_thumb <= 1'b0;
    end else if (w_flush) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_word  <= w_srcWord;
      r_thumb <= w_srcThumb;
      // ARM words are always word aligned; Thumb keeps the entry halfword.
      r_addr  <= {w_srcAddr[ADDR_W-1:2], w_srcThumb & w_srcAddr[1], 1'b0};
      if (!w_srcThumb)
        r_state <= ARM;
      else if (w_srcAddr[1])
        r_state <= HIGH;
      else
        r_state <= LOW;
    end else if ((r_state == LOW) && !in_DecodeStall) begin
      r_state <= HIGH;
      r_addr  <= {r_addr[ADDR_W-1:2], 2'b10};
    end else if (w_lastSlot && !in_DecodeStall) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
    end
  end

  assign out_ValidInstruction_IFID    = r_valid;
  assign out_PipelineRegister_IFID    = r_word;
  assign out_AddressGoWithInstruction = r_addr;
  assign out_ThumbState_IFID          = r_thumb;

endmodule
`default_nettype wire

// File: tb/tb_thumb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_thumb_fetch_sequencer
// Brief   : Directed vector bench for thumb_fetch_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_thumb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetchValid = 1'b0;
  logic [31:0] fetchWord = '0;
  logic [31:0] fetchAddress = '0;
  logic        thumbState = 1'b0;
  logic        decodeStall = 1'b0;
  logic        changePC = 1'b0;
  logic        memChangePC = 1'b0;
  logic        fetchReady;
  logic        validIfid;
  logic [31:0] wordIfid;
  logic [31:0] addrIfid;
  logic        thumbIfid;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  thumb_fetch_sequencer #(.INST_W(32), .ADDR_W(32)) dut (
    .clock                        (clock),
    .reset                        (reset),
    .in_FetchValid                (fetchValid),
    .in_FetchWord                 (fetchWord),
    .in_FetchAddress              (fetchAddress),
    .in_ThumbState                (thumbState),
    .in_DecodeStall               (decodeStall),
    .in_ChangePC                  (changePC),
    .in_MEMChangePC               (memChangePC),
    .out_FetchReady               (fetchReady),
    .out_ValidInstruction_IFID    (validIfid),
    .out_PipelineRegister_IFID    (wordIfid),
    .out_AddressGoWithInstruction (addrIfid),
    .out_ThumbState_IFID          (thumbIfid)
  );

  typedef struct {
    logic        valid;
    logic [31:0] word;
    logic [31:0] addr;
    logic        t;
    logic        stall;
    logic        chg;
    logic        memChg;
    logic        expReady;
    logic        expValid;
    logic [31:0] expWord;
    logic [31:0] expAddr;
    logic        expT;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got 0x%08h want 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] a, input logic t,
                       input logic s, input logic c, input logic m);
    @(negedge clock);
    fetchValid = v; fetchWord = w; fetchAddress = a; thumbState = t;
    decodeStall = s; changePC = c; memChangePC = m;
    #1;
  endtask

  task automatic checkOut(input int idx, input logic v, input logic [31:0] w, input logic [31:0] a, input logic t);
    @(posedge clock);
    #1;
    check("valid", idx, {31'd0, validIfid}, {31'd0, v});
    if (v) begin
      check("word", idx, wordIfid, w);
      check("addr", idx, addrIfid, a);
      check("tbit", idx, {31'd0, thumbIfid}, {31'd0, t});
    end
  endtask

  function automatic vec_t mk(logic v, logic [31:0] w, logic [31:0] a, logic t, logic s, logic c,
                              logic m, logic er, logic ev, logic [31:0] ew, logic [31:0] ea, logic et);
    vec_t r;
    r.valid = v; r.word = w; r.addr = a; r.t = t; r.stall = s; r.chg = c; r.memChg = m;
    r.expReady = er; r.expValid = ev; r.expWord = ew; r.expAddr = ea; r.expT = et;
    return r;
  endfunction

  initial begin
    //             v  word          addr       t  s  c  m  rdy vld expWord       expAddr    expT
    vecs[0]  = mk(1, 32'hE3A00001, 32'h100, 0, 0, 0, 0, 1, 1, 32'hE3A00001, 32'h100, 0);
    vecs[1]  = mk(1, 32'h47702001, 32'h200, 1, 0, 0, 0, 1, 1, 32'h47702001, 32'h200, 1);
    vecs[2]  = mk(1, 32'h11111111, 32'h204, 1, 0, 0, 0, 0, 1, 32'h47702001, 32'h202, 1);
    vecs[3]  = mk(1, 32'h11111111, 32'h204, 1, 0, 0, 0, 1, 1, 32'h11111111, 32'h204, 1);
    vecs[4]  = mk(0, 32'h0,        32'h0,   1, 1, 0, 0, 0, 1, 32'h11111111, 32'h204, 1);
    vecs[5]  = mk(1, 32'h22222222, 32'h208, 1, 1, 0, 0, 0, 1, 32'h11111111, 32'h204, 1);
    vecs[6]  = mk(1, 32'h22222222, 32'h208, 1, 1, 0, 0, 0, 1, 32'h11111111, 32'h204, 1);
    vecs[7]  = mk(0, 32'h0,        32'h0,   1, 0, 0, 0, 0, 1, 32'h11111111, 32'h206, 1);
    vecs[8]  = mk(1, 32'h33333333, 32'h206, 1, 0, 0, 0, 1, 1, 32'h33333333, 32'h206, 1);
    vecs[9]  = mk(1, 32'h44444444, 32'h208, 1, 0, 0, 0, 1, 1, 32'h44444444, 32'h208, 1);
    vecs[10] = mk(1, 32'h55555555, 32'h20C, 1, 0, 0, 1, 0, 0, 32'h0,        32'h0,   0);
    vecs[11] = mk(1, 32'h66666666, 32'h400, 0, 0, 0, 0, 1, 1, 32'h66666666, 32'h400, 0);
    vecs[12] = mk(1, 32'h77777777, 32'h404, 0, 1, 0, 0, 0, 1, 32'h66666666, 32'h400, 0);
    vecs[13] = mk(0, 32'h0,        32'h0,   0, 0, 0, 0, 1, 0, 32'h0,        32'h0,   0);
    vecs[14] = mk(1, 32'h88888888, 32'h502, 1, 0, 0, 0, 1, 1, 32'h88888888, 32'h502, 1);
    vecs[15] = mk(1, 32'h99999999, 32'h600, 0, 1, 1, 0, 0, 0, 32'h0,        32'h0,   0);
    vecs[16] = mk(1, 32'hAAAAAAAA, 32'h603, 0, 0, 0, 0, 1, 1, 32'hAAAAAAAA, 32'h600, 0);
    vecs[17] = mk(1, 32'hBBBBBBBB, 32'h700, 1, 0, 0, 0, 1, 1, 32'hBBBBBBBB, 32'h700, 1);
    vecs[18] = mk(0, 32'h0,        32'h0,   0, 0, 0, 0, 0, 1, 32'hBBBBBBBB, 32'h702, 1);
    vecs[19] = mk(0, 32'h0,        32'h0,   0, 0, 0, 0, 1, 0, 32'h0,        32'h0,   0);

    // Power-on reset, then park the sequencer in HIGH before a mid-cycle reset.
    repeat (2) @(negedge clock);
    reset = 1'b1;
    drive(1, 32'hCAFEBABE, 32'h206, 1, 0, 0, 0);
    checkOut(100, 1, 32'hCAFEBABE, 32'h206, 1);
    drive(0, 32'h0, 32'h0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    check("rst_valid", 101, {31'd0, validIfid}, 32'd0);
    check("rst_addr",  101, addrIfid, 32'd0);
    check("rst_word",  101, wordIfid, 32'd0);
    check("rst_tbit",  101, {31'd0, thumbIfid}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_ready", 102, {31'd0, fetchReady}, 32'd1);

`ifndef THUMB_FETCH_SKID_EN
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].valid, vecs[i].word, vecs[i].addr, vecs[i].t,
            vecs[i].stall, vecs[i].chg, vecs[i].memChg);
      check("ready", i, {31'd0, fetchReady}, {31'd0, vecs[i].expReady});
      checkOut(i, vecs[i].expValid, vecs[i].expWord, vecs[i].expAddr, vecs[i].expT);
    end
`else
    // Two Thumb words back to back give four consecutive halfwords.
    drive(1, 32'h11112222, 32'h300, 1, 0, 0, 0);
    check("sk_ready0", 200, {31'd0, fetchReady}, 32'd1);
    checkOut(200, 1, 32'h11112222, 32'h300, 1);
    drive(1, 32'h33334444, 32'h304, 1, 0, 0, 0);
    check("sk_ready1", 201, {31'd0, fetchReady}, 32'd1);
    checkOut(201, 1, 32'h11112222, 32'h302, 1);
    drive(0, 32'h0, 32'h0, 0, 0, 0, 0);
    checkOut(202, 1, 32'h33334444, 32'h304, 1);
    drive(0, 32'h0, 32'h0, 0, 0, 0, 0);
    checkOut(203, 1, 32'h33334444, 32'h306, 1);
    // Fill both entries, then flush under stall and confirm the skid is gone.
    drive(1, 32'h55556666, 32'h308, 1, 0, 0, 0);
    checkOut(204, 1, 32'h55556666, 32'h308, 1);
    drive(1, 32'h77778888, 32'h30C, 1, 1, 0, 0);
    check("sk_ready_stall", 205, {31'd0, fetchReady}, 32'd1);
    checkOut(205, 1, 32'h55556666, 32'h308, 1);
    drive(0, 32'h0, 32'h0, 0, 1, 1, 0);
    check("sk_ready_flush", 206, {31'd0, fetchReady}, 32'd0);
    checkOut(206, 0, 32'h0, 32'h0, 0);
    drive(0, 32'h0, 32'h0, 0, 0, 0, 0);
    check("sk_ready_after", 207, {31'd0, fetchReady}, 32'd1);
    checkOut(207, 0, 32'h0, 32'h0, 0);
    drive(1, 32'h9999AAAA, 32'h800, 0, 0, 0, 0);
    checkOut(208, 1, 32'h9999AAAA, 32'h800, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
`default_nettype wire
